pixel_uart_tx: RTL and testbench

PIXEL_UART_TX -- requirements
Module: pixel_uart_tx

---
 rtl/pixel_uart_pkg.sv | 28 ++
 rtl/baud_tick_gen.sv | 35 +++
 rtl/pixel_uart_tx.sv | 120 ++++++++++++
 tb/tb_pixel_uart_tx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pixel_uart_pkg.sv
// Shared types and constants for the pixel-over-UART transmitter.
// A pixel goes out as three 8N1 bytes: red, then green, then blue.
package pixel_uart_pkg;

  // FSM states of the transmitter.
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam int BYTES_PER_PIXEL = 3;
  localparam int BITS_PER_BYTE   = 8;

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_PIXEL - 1);
  localparam logic [2:0] LAST_BIT  = 3'(BITS_PER_BYTE - 1);

  // Byte 0 is red [7:0], byte 1 is green [15:8], byte 2 is blue [23:16].
  function automatic logic [7:0] pixel_byte(input logic [23:0] pixel, input logic [1:0] idx);
    case (idx)
      2'd0:    return pixel[7:0];
      2'd1:    return pixel[15:8];
      default: return pixel[23:16];
    endcase
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..DIV-1 and flags the last cycle of each bit period.
// A clear forces the count back to 0 so bit edges line up with FSM transitions.
module baud_tick_gen #(
  parameter int DIV = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pixel_uart_tx.sv
// Serialises 24-bit pixels as three back-to-back 8N1 UART bytes (red, green, blue).
// tx is always driven from a flop; pixel_ready/busy decode directly from the state.
module pixel_uart_tx
  import pixel_uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pixel_in,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        tx,
  output logic        busy
);

  localparam int DIV = CLK_FREQ / BAUD;

  if (DIV < 2) begin : g_div_check
    $error("pixel_uart_tx: CLK_FREQ/BAUD must be at least 2");
  end

  state_e      state_q, state_d;
  logic        tx_q, tx_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] pixel_q, pixel_d;
  logic [7:0]  cur_byte;
  logic        tick;
  logic        baud_clear;

  // Only IDLE holds the timer at zero; every other transition lands on a tick,
  // where the counter wraps to zero on the same edge.
  assign baud_clear = (state_q == IDLE);

  baud_tick_gen #(.DIV(DIV)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (tick)
  );

  assign pixel_ready = (state_q == IDLE);
  assign busy        = ~pixel_ready;
  assign tx          = tx_q;
  assign cur_byte    = pixel_byte(pixel_q, byte_idx_q);

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    pixel_d    = pixel_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pixel_valid) begin
          state_d    = START;
          pixel_d    = pixel_in;
          bit_idx_d  = '0;
          byte_idx_d = '0;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = cur_byte[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          bit_idx_d = '0;
          if (byte_idx_q == LAST_BYTE) begin
            state_d    = IDLE;
            byte_idx_d = '0;
            tx_d       = 1'b1;
          end else begin
            state_d    = START;
            byte_idx_d = byte_idx_q + 2'd1;
            tx_d       = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      pixel_q    <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      pixel_q    <= pixel_d;
    end
  end

endmodule

// File: tb/tb_pixel_uart_tx.sv
// Directed bench for pixel_uart_tx at DIV=8: decodes every frame cycle-by-cycle
// against frames built from the pixel, and checks reset, back-to-back and idle behaviour.
module tb_pixel_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pixel_in = '0;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready;
  logic        tx;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accept_cyc = 0;

  pixel_uart_tx #(.CLK_FREQ(8), .BAUD(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .tx          (tx),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit k (0..29) of the serial image of a pixel: 10-bit 8N1 frames, red first.
  function automatic logic frame_bit(input logic [23:0] pix, input int k);
    int pos;
    int b;
    pos = k % 10;
    b   = k / 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return pix[b*8 + pos - 1];
  endfunction

  // Entered at #1 after an edge with the DUT idle. Offers pix, then watches all
  // 240 frame cycles. hold keeps valid high (next_pix offered); disturb pulses
  // a different pixel mid-frame.
  task automatic run_frame(input logic [23:0] pix, input logic [23:0] next_pix,
                           input bit hold, input bit disturb);
    logic [7:0] got [3];
    int bad;
    int bitk;
    got[0] = '0;
    got[1] = '0;
    got[2] = '0;
    bad = 0;
    check_eq("ready_before_accept", 32'(pixel_ready), 32'd1);
    pixel_in    = pix;
    pixel_valid = 1'b1;
    step();
    accept_cyc = cyc;
    check_eq("tx_start_low", 32'(tx), 32'd0);
    check_eq("busy_after_accept", 32'(busy), 32'd1);
    check_eq("ready_after_accept", 32'(pixel_ready), 32'd0);
    if (hold) pixel_in = next_pix;
    else pixel_valid = 1'b0;
    for (int i = 0; i < 240; i++) begin
      if (disturb && i == 50) begin
        pixel_in    = 24'h123456;
        pixel_valid = 1'b1;
      end
      if (disturb && i == 53) pixel_valid = 1'b0;
      bitk = i / 8;
      if (tx !== frame_bit(pix, bitk)) bad++;
      if (busy !== 1'b1 || pixel_ready !== 1'b0) bad++;
      if ((i % 8) == 4 && (bitk % 10) >= 1 && (bitk % 10) <= 8)
        got[bitk / 10][(bitk % 10) - 1] = tx;
      if (i < 239) step();
    end
    check_eq("ready_low_last_stop_cycle", 32'(pixel_ready), 32'd0);
    step();
    check_eq("ready_back_at_240", 32'(pixel_ready), 32'd1);
    check_eq("tx_idle_after_frame", 32'(tx), 32'd1);
    check_eq("bit_timing_errors", 32'(bad), 32'd0);
    check_eq("byte_red", 32'(got[0]), 32'(pix[7:0]));
    check_eq("byte_green", 32'(got[1]), 32'(pix[15:8]));
    check_eq("byte_blue", 32'(got[2]), 32'(pix[23:16]));
    $display("pixel %06h accepted at cycle %0d: bytes %02h %02h %02h", pix, accept_cyc,
             got[0], got[1], got[2]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_cyc;
    int idle_bad;

    #2 rst = 1'b0;
    step();
    step();
    check_eq("reset_tx", 32'(tx), 32'd1);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_ready", 32'(pixel_ready), 32'd1);
    rst = 1'b1;
    step();
    $display("reset released at cycle %0d", cyc);

    // Single pixel, valid for one cycle.
    run_frame(24'h3CA50F, 24'h0, 1'b0, 1'b0);
    step();

    // valid held: second pixel accepted 241 cycles after the first.
    run_frame(24'hFFFFFF, 24'h000000, 1'b1, 1'b0);
    first_cyc = accept_cyc;
    run_frame(24'h000000, 24'h0, 1'b0, 1'b0);
    check_eq("held_valid_period", 32'(accept_cyc - first_cyc), 32'd241);
    $display("held-valid pixels accepted at cycles %0d and %0d", first_cyc, accept_cyc);
    step();

    // Reset 100 cycles into a frame.
    pixel_in    = 24'hDEADBE;
    pixel_valid = 1'b1;
    step();
    pixel_valid = 1'b0;
    repeat (100) step();
    check_eq("busy_before_midframe_reset", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("midframe_reset_tx", 32'(tx), 32'd1);
    check_eq("midframe_reset_busy", 32'(busy), 32'd0);
    check_eq("midframe_reset_ready", 32'(pixel_ready), 32'd1);
    step();
    step();
    rst = 1'b1;
    step();
    check_eq("tx_idle_after_reset_release", 32'(tx), 32'd1);
    $display("mid-frame reset applied and released at cycle %0d", cyc);
    run_frame(24'h5AC381, 24'h0, 1'b0, 1'b0);
    step();

    // A different pixel pulsed while busy must not appear on tx.
    run_frame(24'h81C35A, 24'h0, 1'b0, 1'b1);
    step();

    // Long idle.
    pixel_valid = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) idle_bad++;
      step();
    end
    check_eq("idle_1000_cycles", 32'(idle_bad), 32'd0);
    $display("idle window of 1000 cycles ended at cycle %0d", cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
